wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; no parameters (depth fixed at 4 entries, 16-bit data, 3-bit register select).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 a_valid  input  1  ALU result present on port A this cycle.
REQ-005 a_regsel / a_data  input  3 / 16  destination register and value for port A.
REQ-006 b_valid  input  1  load result present on port B this cycle.
REQ-007 b_regsel / b_data  input  3 / 16  destination register and value for port B.
REQ-008 in_ready  output  1  queue can accept both ports this cycle.
REQ-009 write / writeregsel / writedata  output  1 / 3 / 16  single write port driven into the register file.
REQ-010 look1sel, look2sel  input  3 each  decode-stage register selects to search.
REQ-011 hit1 / hit1data, hit2 / hit2data  output  1 / 16 each  pending value found for look1sel / look2sel.
REQ-012 count  output  3  number of valid entries (0..4).
REQ-013 err  output  1  sticky protocol-error flag.

Function
REQ-014 Storage SHALL be a 4-entry circular FIFO (head/tail pointers, 2-bit, wrap 3->0) of {regsel, data}.
REQ-015 in_ready SHALL be combinational: 1 when count <= 2, else 0.
REQ-016 An input is accepted when its valid is 1 and in_ready is 1; accepted entries are written at the rising edge.
REQ-017 Both ports accepted in one cycle: A SHALL be enqueued first (older), B second (younger).
REQ-018 Drain: when count != 0, write = 1 and writeregsel/writedata = head entry; head SHALL advance at the edge (one drain per cycle, no stall input).
REQ-019 When count = 0, write = 0 and writeregsel/writedata = 0.
REQ-020 An empty queue SHALL NOT pass inputs straight to the write port; minimum latency is 1 cycle (accepted at edge N, write high in cycle N+1, register file updated at edge N+1).
REQ-021 count_next = count + accepted(A) + accepted(B) - drained; it SHALL never exceed 4 and never underflow.
REQ-022 Lookup (each port independent, combinational) SHALL search, youngest first: accepted B input this cycle, accepted A input this cycle, then stored entries from tail-1 back to head (including the entry draining this cycle).
REQ-023 hitN = 1 if any searched source matches lookNsel; hitNdata = value of the youngest match; hitN = 0 and hitNdata = 0 otherwise.
REQ-024 Duplicate destinations in the queue SHALL be retained and drained in order; lookup returns only the youngest.
REQ-025 Register 0 SHALL be treated like any other register (no hardwired zero).
REQ-026 err SHALL set at the edge when a_valid or b_valid is 1 while in_ready is 0, and remain 1 until reset; the rejected input SHALL be dropped and state otherwise unaffected.

Reset
REQ-027 On rst low: head = tail = 0, count = 0, err = 0; write, hit1, hit2 = 0; entry storage need not be cleared.
REQ-028 Reset asserted mid-operation SHALL discard all pending entries; no write is issued in the cycle following deassertion unless new input was accepted.

Verification
REQ-029 Single write: a_valid, a_regsel=3, a_data=0x1234 for one cycle on empty queue -> next cycle write=1, writeregsel=3, writedata=0x1234, count=1; following cycle write=0, count=0.
REQ-030 Dual enqueue order: A(r1=0x00AA) and B(r2=0x00BB) same cycle -> writes r1 then r2 on consecutive cycles; count 2,1,0.
REQ-031 Backpressure/full: both ports valid every cycle -> count 2,3, in_ready drops at count 3, err stays 0 if stimulus honours in_ready; forcing a_valid with in_ready=0 -> err=1 sticky, count unchanged by the dropped input.
REQ-032 Lookup priority: queue holds r5=0x1111 then r5=0x2222, B input r5=0x3333 this cycle, look1sel=5 -> hit1=1, hit1data=0x3333; B absent -> 0x2222; look2sel=6 -> hit2=0, hit2data=0.
REQ-033 Wrap-around: 10 consecutive single enqueues (pointers wrap twice) -> write sequence matches input order exactly, no loss or duplication.
REQ-034 Async reset: assert rst low with count=3 between edges -> count, write, err, hit1, hit2 go 0 immediately; after release, write stays 0 with no input.

Source files
------------

// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- 4-entry write-back queue between execute/load results and the
// register file.
//
// Two producers (port A: ALU result, port B: load result) may each deliver one
// {regsel, data} pair per cycle. Accepted pairs go into a circular FIFO (A is
// older than B when both arrive together). The oldest entry is drained onto
// the single register-file write port every cycle the queue is non-empty.
// Decode can look up two register selects; the youngest pending value wins,
// including values being accepted this very cycle.
//
// Ports
//   clk                       clock, rising-edge
//   rst                       asynchronous reset, active low
//   a_valid/a_regsel/a_data   port A producer (1/3/16)
//   b_valid/b_regsel/b_data   port B producer (1/3/16)
//   in_ready                  both ports may present a value this cycle
//   write/writeregsel/writedata  register-file write port (head entry)
//   look1sel/look2sel         decode-stage register selects
//   hit1/hit1data, hit2/hit2data  youngest pending value for each select
//   count                     number of valid entries (0..4)
//   err                       sticky flag: producer presented while not ready
// ---------------------------------------------------------------------------
module wb_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [2:0]  a_regsel,
    input  logic [15:0] a_data,
    input  logic        b_valid,
    input  logic [2:0]  b_regsel,
    input  logic [15:0] b_data,
    output logic        in_ready,
    output logic        write,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    input  logic [2:0]  look1sel,
    input  logic [2:0]  look2sel,
    output logic        hit1,
    output logic [15:0] hit1data,
    output logic        hit2,
    output logic [15:0] hit2data,
    output logic [2:0]  count,
    output logic        err
);

    logic [1:0]  head_q, head_d;
    logic [1:0]  tail_q, tail_d;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;

    logic [2:0]  sel_mem_q [4];
    logic [15:0] dat_mem_q [4];

    logic        acc_a_s;
    logic        acc_b_s;
    logic        drain_s;
    logic [1:0]  b_slot_s;

    // At most one entry drains per cycle, so with two free slots both
    // producers always fit; ready therefore only depends on the count.
    assign in_ready = (count_q <= 3'd2);

    // Gating with rst keeps a producer that is active during reset from
    // showing up as a lookup hit or being written into storage.
    assign acc_a_s  = rst & a_valid & in_ready;
    assign acc_b_s  = rst & b_valid & in_ready;
    assign drain_s  = (count_q != 3'd0);
    assign b_slot_s = acc_a_s ? (tail_q + 2'd1) : tail_q;

    assign count = count_q;
    assign err   = err_q;

    // Next-state for pointers, occupancy and the sticky error flag.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;

        if (drain_s) begin
            head_d = head_q + 2'd1;
        end else begin
            head_d = head_q;
        end

        tail_d  = tail_q + {1'b0, acc_a_s} + {1'b0, acc_b_s};
        count_d = count_q + {2'b00, acc_a_s} + {2'b00, acc_b_s} - {2'b00, drain_s};

        if ((a_valid | b_valid) & ~in_ready) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= 2'd0;
            tail_q  <= 2'd0;
            count_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Entry storage; contents are only meaningful under count, so no reset.
    always_ff @(posedge clk) begin
        if (acc_a_s) begin
            sel_mem_q[tail_q] <= a_regsel;
            dat_mem_q[tail_q] <= a_data;
        end
        if (acc_b_s) begin
            sel_mem_q[b_slot_s] <= b_regsel;
            dat_mem_q[b_slot_s] <= b_data;
        end
    end

    // Register-file write port presents the head entry whenever non-empty.
    always_comb begin
        write       = 1'b0;
        writeregsel = 3'd0;
        writedata   = 16'd0;
        if (drain_s) begin
            write       = 1'b1;
            writeregsel = sel_mem_q[head_q];
            writedata   = dat_mem_q[head_q];
        end else begin
            write       = 1'b0;
            writeregsel = 3'd0;
            writedata   = 16'd0;
        end
    end

    // Lookup: scan oldest to youngest so later matches overwrite earlier
    // ones; the entry draining this cycle is still searched, and this
    // cycle's accepted A then B inputs are the youngest sources.
    always_comb begin
        hit1     = 1'b0;
        hit1data = 16'd0;
        hit2     = 1'b0;
        hit2data = 16'd0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < count_q) && (sel_mem_q[head_q + 2'(i)] == look1sel)) begin
                hit1     = 1'b1;
                hit1data = dat_mem_q[head_q + 2'(i)];
            end else begin
                hit1     = hit1;
                hit1data = hit1data;
            end
            if ((3'(i) < count_q) && (sel_mem_q[head_q + 2'(i)] == look2sel)) begin
                hit2     = 1'b1;
                hit2data = dat_mem_q[head_q + 2'(i)];
            end else begin
                hit2     = hit2;
                hit2data = hit2data;
            end
        end
        if (acc_a_s && (a_regsel == look1sel)) begin
            hit1     = 1'b1;
            hit1data = a_data;
        end else begin
            hit1     = hit1;
            hit1data = hit1data;
        end
        if (acc_a_s && (a_regsel == look2sel)) begin
            hit2     = 1'b1;
            hit2data = a_data;
        end else begin
            hit2     = hit2;
            hit2data = hit2data;
        end
        if (acc_b_s && (b_regsel == look1sel)) begin
            hit1     = 1'b1;
            hit1data = b_data;
        end else begin
            hit1     = hit1;
            hit1data = hit1data;
        end
        if (acc_b_s && (b_regsel == look2sel)) begin
            hit2     = 1'b1;
            hit2data = b_data;
        end else begin
            hit2     = hit2;
            hit2data = hit2data;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue -- self-checking bench for wb_queue.
// A queue-based reference model is compared against every output at each
// falling clock edge; directed sequences add hand-computed literal checks.
// Inputs change 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [2:0]  a_regsel = 3'd0;
    logic [15:0] a_data = 16'd0;
    logic        b_valid = 1'b0;
    logic [2:0]  b_regsel = 3'd0;
    logic [15:0] b_data = 16'd0;
    logic [2:0]  look1sel = 3'd0;
    logic [2:0]  look2sel = 3'd0;
    logic        in_ready;
    logic        write;
    logic [2:0]  writeregsel;
    logic [15:0] writedata;
    logic        hit1;
    logic [15:0] hit1data;
    logic        hit2;
    logic [15:0] hit2data;
    logic [2:0]  count;
    logic        err;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    wb_queue dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_regsel(a_regsel), .a_data(a_data),
        .b_valid(b_valid), .b_regsel(b_regsel), .b_data(b_data),
        .in_ready(in_ready),
        .write(write), .writeregsel(writeregsel), .writedata(writedata),
        .look1sel(look1sel), .look2sel(look2sel),
        .hit1(hit1), .hit1data(hit1data), .hit2(hit2), .hit2data(hit2data),
        .count(count), .err(err)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain list of pending {regsel, data}, oldest first.
    logic [18:0] mq[$];
    logic        m_err = 1'b0;
    logic        m_rdy;

    function automatic logic [16:0] mlook(input logic [2:0] sel);
        logic [18:0] src[$];
        logic        rdy;
        rdy = (mq.size() <= 2);
        src = mq;
        if (rst && a_valid && rdy) src.push_back({a_regsel, a_data});
        if (rst && b_valid && rdy) src.push_back({b_regsel, b_data});
        for (int i = src.size() - 1; i >= 0; i--) begin
            if (src[i][18:16] == sel) return {1'b1, src[i][15:0]};
        end
        return 17'd0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            m_rdy = (mq.size() <= 2);
            if ((a_valid || b_valid) && !m_rdy) m_err = 1'b1;
            if (mq.size() != 0) void'(mq.pop_front());
            if (a_valid && m_rdy) mq.push_back({a_regsel, a_data});
            if (b_valid && m_rdy) mq.push_back({b_regsel, b_data});
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        logic [16:0] l1;
        logic [16:0] l2;
        l1 = mlook(look1sel);
        l2 = mlook(look2sel);
        check("m_in_ready", in_ready, (mq.size() <= 2) ? 1 : 0);
        check("m_count", count, mq.size());
        check("m_err", err, m_err);
        check("m_write", write, (mq.size() != 0) ? 1 : 0);
        check("m_wdata", {writeregsel, writedata}, (mq.size() != 0) ? mq[0] : 19'd0);
        check("m_hit1", {hit1, hit1data}, l1);
        check("m_hit2", {hit2, hit2data}, l2);
    end

    task automatic drive(input logic av, input logic [2:0] ar, input logic [15:0] ad,
                         input logic bv, input logic [2:0] br, input logic [15:0] bd);
        @(posedge clk);
        #1;
        a_valid = av; a_regsel = ar; a_data = ad;
        b_valid = bv; b_regsel = br; b_data = bd;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #3;
        check("rst_count", count, 3'd0);
        check("rst_write", write, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_hit1", hit1, 1'b0);
        #20 rst = 1'b1;

        // Single write with 1-cycle minimum latency
        look1sel = 3'd3;
        drive(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'd0);
        settle();
        check("single_nopass", write, 1'b0);
        check("single_inlook", {hit1, hit1data}, {1'b1, 16'h1234});
        idle();
        settle();
        check("single_write", {write, writeregsel, writedata}, {1'b1, 3'd3, 16'h1234});
        check("single_count1", count, 3'd1);
        idle();
        settle();
        check("single_done", {write, count}, {1'b0, 3'd0});

        // Dual enqueue: A older than B
        drive(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd2, 16'h00BB);
        idle();
        settle();
        check("dual_first", {write, writeregsel, writedata, count}, {1'b1, 3'd1, 16'h00AA, 3'd2});
        idle();
        settle();
        check("dual_second", {write, writeregsel, writedata, count}, {1'b1, 3'd2, 16'h00BB, 3'd1});
        idle();
        settle();
        check("dual_empty", {write, count}, {1'b0, 3'd0});

        // Lookup priority
        look1sel = 3'd5;
        look2sel = 3'd6;
        drive(1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 16'h2222);
        drive(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 16'h3333);
        settle();
        check("look_count", count, 3'd2);
        check("look_b_wins", {hit1, hit1data}, {1'b1, 16'h3333});
        check("look_miss", {hit2, hit2data}, {1'b0, 16'h0000});
        b_valid = 1'b0;
        #1;
        check("look_stored", {hit1, hit1data}, {1'b1, 16'h2222});
        idle();
        idle();
        settle();
        check("look_drained", count, 3'd0);

        // Wrap-around: ten single enqueues, register 0 included
        look1sel = 3'd0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i), 16'hA000 + 16'(i), 1'b0, 3'd0, 16'd0);
            settle();
            if (i > 0) begin
                check("wrap_write", {write, writeregsel, writedata},
                      {1'b1, 3'(i - 1), 16'hA000 + 16'(i - 1)});
            end
        end
        idle();
        settle();
        check("wrap_last", {write, writeregsel, writedata}, {1'b1, 3'd1, 16'hA009});
        idle();
        settle();
        check("wrap_empty", count, 3'd0);

        // Backpressure and sticky error
        drive(1'b1, 3'd1, 16'hC001, 1'b1, 3'd2, 16'hC002);
        drive(1'b1, 3'd3, 16'hC003, 1'b1, 3'd4, 16'hC004);
        settle();
        check("bp_count2", {count, in_ready}, {3'd2, 1'b1});
        idle();
        settle();
        check("bp_full", {count, in_ready, err}, {3'd3, 1'b0, 1'b0});
        drive(1'b1, 3'd5, 16'hC005, 1'b1, 3'd6, 16'hC006);
        drive(1'b1, 3'd7, 16'hC007, 1'b0, 3'd0, 16'd0);
        settle();
        check("bp_force", {count, in_ready, err}, {3'd3, 1'b0, 1'b0});
        idle();
        settle();
        check("bp_err_set", {count, err}, {3'd2, 1'b1});
        idle();
        idle();
        idle();
        settle();
        check("bp_err_sticky", {count, err}, {3'd0, 1'b1});

        // Asynchronous reset mid-operation
        look1sel = 3'd7;
        look2sel = 3'd6;
        drive(1'b1, 3'd7, 16'hD001, 1'b1, 3'd6, 16'hD002);
        drive(1'b1, 3'd7, 16'hD003, 1'b1, 3'd6, 16'hD004);
        idle();
        settle();
        check("ar_pre", {count, hit1, hit1data, err}, {3'd3, 1'b1, 16'hD003, 1'b1});
        check("ar_pre_hit2", {hit2, hit2data}, {1'b1, 16'hD004});
        #2 rst = 1'b0;
        #1;
        check("ar_count", count, 3'd0);
        check("ar_outs", {write, err, hit1, hit2}, 4'b0000);
        #1 rst = 1'b1;
        idle();
        settle();
        check("ar_after1", {write, count}, {1'b0, 3'd0});
        idle();
        settle();
        check("ar_after2", write, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
